// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop sequence controller:
// FSM state encoding and the default counter width.
package tff_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop cell with toggle enable, synchronous clear and
// synchronous active-low reset (reset beats clear beats toggle).
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_seq_ctrl.sv
// Up/down run controller driving a bank of T flip-flops: the FSM only issues
// per-bit toggle enables and a synchronous clear, the cells hold the count.
module tff_seq_ctrl
    import tff_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_t           state;
    state_t           next_state;
    logic             dir_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] toggle;
    logic             clr;
    logic             step;
    logic             latch;
    logic             wrap_next;
    logic             ones;
    logic             zeros;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
            dir_q   <= 1'b0;
            limit_q <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state == RUN);
            done  <= (next_state == DONE);
            wrap  <= wrap_next;
            if (latch) begin
                dir_q   <= dir;
                limit_q <= limit;
            end
        end
    end

    // Reaching the limit takes precedence over stop, so a stop that lands on
    // the final count still completes the run.
    always_comb begin
        next_state = state;
        clr        = 1'b0;
        step       = 1'b0;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    latch      = 1'b1;
                    clr        = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (count == limit_q) begin
                    next_state = DONE;
                end else if (stop) begin
                    next_state = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Bit i toggles when every lower bit is 1 (up) or 0 (down); after the
    // loop, ones/zeros say whether the whole count is all-ones/all-zeros.
    always_comb begin
        mask  = '0;
        ones  = 1'b1;
        zeros = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = dir_q ? ones : zeros;
            ones    = ones & count[i];
            zeros   = zeros & ~count[i];
        end
    end

    assign toggle    = step ? mask : '0;
    assign wrap_next = step & (dir_q ? ones : zeros);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .t   (toggle[i]),
            .q   (count[i])
        );
    end

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Scoreboard bench for tff_seq_ctrl: a behavioural arithmetic model predicts
// every cycle's outputs, which are queued at drive time and checked on negedge.
module tb_tff_seq_ctrl;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    typedef struct {
        int count;
        bit busy;
        bit done;
        bit wrap;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         dir = 1'b0;
    logic [W-1:0] limit = '0;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         wrap;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   bcnt = 0;
    int   dcnt = 0;
    int   wcnt = 0;

    int   m_state = 0;
    int   m_count = 0;
    int   m_lim = 0;
    bit   m_dir = 1'b0;

    tff_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .dir   (dir),
        .limit (limit),
        .count (count),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge,
    // and queue what the DUT must show after that edge.
    task automatic applyStimulus(input logic r, input logic s, input logic p,
                                 input logic d, input logic [W-1:0] l);
        exp_t e;
        @(negedge clk);
        #1;
        rst   = r;
        start = s;
        stop  = p;
        dir   = d;
        limit = l;
        e.wrap = 1'b0;
        if (!r) begin
            m_state = 0;
            m_count = 0;
            m_dir   = 1'b0;
            m_lim   = 0;
        end else begin
            case (m_state)
                0: begin
                    if (s) begin
                        m_dir   = d;
                        m_lim   = int'(l);
                        m_count = 0;
                        m_state = 1;
                    end
                end
                1: begin
                    if (m_count == m_lim) begin
                        m_state = 2;
                    end else if (p) begin
                        m_state = 0;
                    end else if (m_dir) begin
                        e.wrap  = (m_count == MAXV);
                        m_count = (m_count + 1) % (MAXV + 1);
                    end else begin
                        e.wrap  = (m_count == 0);
                        m_count = (m_count + MAXV) % (MAXV + 1);
                    end
                end
                default: m_state = 0;
            endcase
        end
        e.count = m_count;
        e.busy  = (m_state == 1);
        e.done  = (m_state == 2);
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input logic d, input logic [W-1:0] l);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, d, l);
    endtask

    task automatic drain();
        repeat (4) begin
            if (sb.size() > 0) begin
                @(negedge clk);
                #2;
            end
        end
        checkOutput("drain", sb.size(), 0);
    endtask

    task automatic newScenario();
        drain();
        bcnt = 0;
        dcnt = 0;
        wcnt = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput($sformatf("count@%0d", cyc), int'(count), e.count);
            checkOutput($sformatf("busy@%0d", cyc), int'(busy), int'(e.busy));
            checkOutput($sformatf("done@%0d", cyc), int'(done), int'(e.done));
            checkOutput($sformatf("wrap@%0d", cyc), int'(wrap), int'(e.wrap));
            if (busy) bcnt++;
            if (done) dcnt++;
            if (wrap) wcnt++;
        end
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
        idle(1, 1'b0, 4'd0);

        newScenario();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
        idle(8, 1'b0, 4'd0);
        drain();
        checkOutput("up5_busy_cycles", bcnt, 6);
        checkOutput("up5_done_pulses", dcnt, 1);
        checkOutput("up5_wraps", wcnt, 0);

        newScenario();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd13);
        idle(6, 1'b1, 4'd0);
        drain();
        checkOutput("dn13_busy_cycles", bcnt, 4);
        checkOutput("dn13_done_pulses", dcnt, 1);
        checkOutput("dn13_wraps", wcnt, 1);

        newScenario();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd15);
        idle(7, 1'b1, 4'd15);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd15);
        idle(3, 1'b1, 4'd15);
        drain();
        checkOutput("stop7_done_pulses", dcnt, 0);
        checkOutput("stop7_busy_cycles", bcnt, 8);
        checkOutput("stop7_hold", int'(count), 7);

        newScenario();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd3);
        idle(3, 1'b1, 4'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd3);
        idle(3, 1'b1, 4'd3);
        drain();
        checkOutput("stop_at_lim_done", dcnt, 1);
        checkOutput("stop_at_lim_count", int'(count), 3);

        newScenario();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd12);
        idle(9, 1'b1, 4'd12);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd12);
        idle(3, 1'b1, 4'd12);
        drain();
        checkOutput("rst_mid_done", dcnt, 0);
        checkOutput("rst_mid_count", int'(count), 0);

        newScenario();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
        idle(5, 1'b0, 4'd2);
        drain();
        checkOutput("restart_done", dcnt, 1);
        checkOutput("restart_count", int'(count), 4);

        newScenario();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        idle(3, 1'b1, 4'd0);
        drain();
        checkOutput("lim0_busy_cycles", bcnt, 1);
        checkOutput("lim0_done", dcnt, 1);
        checkOutput("lim0_wraps", wcnt, 0);

        newScenario();
        for (int i = 0; i < 60; i++) begin
            applyStimulus(($urandom_range(31) != 0), ($urandom_range(3) == 0),
                          ($urandom_range(7) == 0), 1'($urandom_range(1)),
                          4'($urandom_range(MAXV)));
        end
        idle(3, 1'b0, 4'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/tff_seq_ctrl.md
TFF_SEQ_CTRL -- requirements
Module: tff_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, counter width; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 start  input  1  begin a count run; honoured only in IDLE.
REQ-005 stop  input  1  abort the current run; honoured only in RUN.
REQ-006 dir  input  1  count direction, 1 = up, 0 = down; sampled at start.
REQ-007 limit  input  WIDTH  terminal value; sampled at start.
REQ-008 count  output  WIDTH  current counter value (T flip-flop bank outputs).
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse on normal completion.
REQ-011 wrap  output  1  one-cycle pulse when a step wraps (max->0 up, 0->max down).

Function
REQ-012 Counter storage SHALL be WIDTH T flip-flop cells; the controller SHALL drive only per-bit toggle enables and a synchronous clear.
REQ-013 FSM states SHALL be IDLE, RUN and DONE, encoded 2 bits.
REQ-014 In IDLE with start=1, the block SHALL latch dir and limit, clear count to 0, and enter RUN on the same edge.
REQ-015 In RUN with count != limit and stop=0, count SHALL step by one per cycle in the latched direction.
REQ-016 Up toggle rule: bit i toggles when all lower bits are 1; bit 0 always toggles.
REQ-017 Down toggle rule: bit i toggles when all lower bits are 0; bit 0 always toggles.
REQ-018 Arithmetic SHALL be modulo 2^WIDTH; an up step from 2^WIDTH-1 or a down step from 0 SHALL assert wrap for that cycle's following edge only.
REQ-019 In RUN with count == limit, no bit SHALL toggle, and the FSM SHALL enter DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 In RUN with stop=1 and count != limit, the FSM SHALL return to IDLE with count held, and done SHALL NOT pulse.
REQ-022 In RUN with stop=1 and count == limit simultaneously, completion SHALL win: enter DONE, done pulses.
REQ-023 start outside IDLE and stop outside RUN SHALL be ignored; changes to dir or limit during RUN SHALL have no effect.
REQ-024 count SHALL hold its value in IDLE and DONE.
REQ-025 busy, done and wrap SHALL be registered outputs; busy=1 exactly while state == RUN.
REQ-026 With limit=0 and dir=1, a run SHALL complete one cycle after entering RUN: count 0, done pulse, no wrap.
REQ-027 With dir=0 and limit!=0, count SHALL go 0 -> 2^WIDTH-1 (wrap pulse) and then descend to limit.

Reset
REQ-028 When rst=0 at a clock edge, the block SHALL go to IDLE with count=0, busy=0, done=0 and wrap=0, regardless of the current state.
REQ-029 Reset asserted mid-run SHALL abort the run without a done pulse.
REQ-030 Reset SHALL take priority over start, stop and all toggles.

Structure
REQ-031 The state encoding constants (IDLE=0, RUN=1, DONE=2) and the default WIDTH SHALL live in a shared package, tff_pkg.
REQ-032 One sub-module, tff_cell, SHALL be used: a T flip-flop with enable T, synchronous clear, and synchronous active-low reset, instantiated WIDTH times in a generate loop.
REQ-033 Toggle-enable generation and the FSM SHALL reside in tff_seq_ctrl.

Verification
REQ-034 Release reset, set WIDTH=4, dir=1, limit=5, and pulse start -> count goes 0,1,2,3,4,5; busy is high for 6 cycles; done pulses once; wrap is never asserted.
REQ-035 Set dir=0, limit=13, and pulse start -> count goes 0,15 (wrap=1),14,13; then done pulses and busy falls.
REQ-036 Set dir=1, limit=15, and assert stop when count=7 -> the FSM returns to IDLE, count holds at 7, and done never pulses.
REQ-037 Assert stop on the cycle count==limit=3 -> done pulses and count=3.
REQ-038 Assert rst=0 when count=9 during an up run with limit=12 -> the next edge gives count=0, busy=0, and no done pulse.
REQ-039 Re-pulse start and change limit during RUN (limit=4, then 2) -> the start pulse is ignored and the run terminates at 4.
